// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: op codes, FSM states and
// the op-code decode used by start acceptance.
package div_unit_pkg;

  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_DIVU = 5'b01111;
  localparam logic [4:0] OP_REM  = 5'b10000;
  localparam logic [4:0] OP_REMU = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divider request/response bundle; master is the pipeline side.
interface div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start_i;
  logic [4:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] res_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, res_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, res_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] quot_q, rem_q, dvsr_q, res_q;
  logic                  rem_sel_q, neg_q_q, neg_r_q;

  logic                  op_signed, op_rem, accept, special, last_iter;
  logic [DATA_WIDTH-1:0] abs_a, abs_b, special_res;
  logic [DATA_WIDTH:0]   rem_sh, trial;
  logic [DATA_WIDTH-1:0] quot_nx, rem_nx, fixed_res;

  // Operand decode, acceptance and special-case detection at the request.
  always_comb begin
    op_signed = (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    op_rem    = (bus.op_i == OP_REM) || (bus.op_i == OP_REMU);
    accept    = bus.start_i && is_div_op(bus.op_i) && !bus.flush_i &&
                (state_q != ST_CALC);
    abs_a     = (op_signed && bus.a_i[DATA_WIDTH-1]) ? '0 - bus.a_i : bus.a_i;
    abs_b     = (op_signed && bus.b_i[DATA_WIDTH-1]) ? '0 - bus.b_i : bus.b_i;
    special   = 1'b0;
    special_res = '0;
    if (bus.b_i == '0) begin
      special     = 1'b1;
      special_res = op_rem ? bus.a_i : '1;
    end else if (op_signed && bus.a_i == MIN_NEG && bus.b_i == '1) begin
      special     = 1'b1;
      special_res = op_rem ? '0 : MIN_NEG;
    end
  end

  // One restoring step plus sign fix-up of the would-be final values.
  always_comb begin
    rem_sh    = {rem_q, quot_q[DATA_WIDTH-1]};
    trial     = rem_sh - {1'b0, dvsr_q};
    if (!trial[DATA_WIDTH]) begin
      rem_nx  = trial[DATA_WIDTH-1:0];
      quot_nx = {quot_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_nx  = rem_sh[DATA_WIDTH-1:0];
      quot_nx = {quot_q[DATA_WIDTH-2:0], 1'b0};
    end
    if (rem_sel_q) fixed_res = neg_r_q ? '0 - rem_nx : rem_nx;
    else           fixed_res = neg_q_q ? '0 - quot_nx : quot_nx;
    last_iter = (state_q == ST_CALC) && !bus.flush_i && (cnt_q == '0);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush always wins over a concurrent start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (bus.flush_i)       state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_DONE;
      end
      ST_DONE: state_d = accept ? (special ? ST_DONE : ST_CALC) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    bus.busy_o = (state_q == ST_CALC);
    bus.done_o = (state_q == ST_DONE);
    bus.res_o  = res_q;
  end

  // Datapath registers; res_q loads only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
    end else if (accept) begin
      rem_sel_q <= op_rem;
      cnt_q     <= CW'(DATA_WIDTH - 1);
      if (special) begin
        res_q <= special_res;
      end else begin
        quot_q  <= abs_a;
        rem_q   <= '0;
        dvsr_q  <= abs_b;
        neg_q_q <= op_signed && (bus.a_i[DATA_WIDTH-1] ^ bus.b_i[DATA_WIDTH-1]);
        neg_r_q <= op_signed && bus.a_i[DATA_WIDTH-1];
      end
    end else if (state_q == ST_CALC && !bus.flush_i) begin
      quot_q <= quot_nx;
      rem_q  <= rem_nx;
      cnt_q  <= cnt_q - 1'b1;
      if (last_iter) res_q <= fixed_res;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares on every done_o pulse, including the completion cycle.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_WIDTH(W)) bus();
  div_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] res;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t        scb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the RISC-V zero-divisor rules.
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sbv, ua, ub, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    r   = 0;
    case (op)
      OP_DIV:  r = (b == 0) ? -1 : sa / sbv;
      OP_REM:  r = (b == 0) ? sa : sa % sbv;
      OP_DIVU: r = (b == 0) ? -1 : ua / ub;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) ||
           ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Drive a request at the current (negedge) time; optionally record expectation.
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_it, input string nm);
    exp_t e;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    if (expect_it) begin
      e.res  = ref_res(op, a, b);
      e.due  = cyc + 1 + (is_special(op, a, b) ? 0 : W);
      e.name = nm;
      scb.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (scb.size() == 0) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL timeout pending=%0d actual=no_done required=done", scb.size());
    scb.delete();
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input string nm);
    @(negedge clk);
    drive(op, a, b, 1'b1, nm);
    @(negedge clk);
    bus.start_i = 1'b0;
    drain(W + 10);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h8000_0000;
    case ($urandom_range(0, 9))
      0, 1, 2: return corners[$urandom_range(0, 4)];
      3, 4:    return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every done_o pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && bus.done_o) begin
        if (scb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=res_%h required=no_done", bus.res_o);
        end else begin
          e = scb.pop_front();
          chk(e.name, bus.res_o, e.res);
          chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    logic [31:0] prev;
    logic [4:0]  ops [4];
    bit          seen;
    ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

    reset       = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_res", bus.res_o, 32'd0);
    reset = 1'b0;

    run(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run(OP_REMU, 32'd100, 32'd7, "remu_100_7");
    run(OP_DIV, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
    run(OP_REM, 32'hFFFF_FF9C, 32'd7, "rem_m100_7");
    run(OP_REM, 32'd100, 32'hFFFF_FFF9, "rem_100_m7");
    run(OP_DIV, 32'd5, 32'd0, "div_by_zero");
    run(OP_REMU, 32'd5, 32'd0, "remu_by_zero");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Non-divide op code must be ignored.
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 5'b00000; bus.a_i = 32'd9; bus.b_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("nondiv_busy", 32'(bus.busy_o), 32'd0);
    chk("nondiv_done", 32'(bus.done_o), 32'd0);

    // Start together with flush is dropped.
    drive(OP_DIVU, 32'd50, 32'd3, 1'b0, "");
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    chk("flush_start_busy", 32'(bus.busy_o), 32'd0);
    chk("flush_start_done", 32'(bus.done_o), 32'd0);

    // Flush at T+10 of a divu: no pulse, idle at T+11, result held.
    prev = bus.res_o;
    drive(OP_DIVU, 32'd1234, 32'd5, 1'b0, "");
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_busy", 32'(bus.busy_o), 32'd0);
    chk("flush_res", bus.res_o, prev);
    repeat (W + 4) @(negedge clk);
    chk("flush_res_later", bus.res_o, prev);

    // Reset in the middle of an op clears outputs at once.
    drive(OP_DIVU, 32'd999, 32'd4, 1'b0, "");
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_done", 32'(bus.done_o), 32'd0);
    chk("midrst_res", bus.res_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // start during CALC with other operands is ignored.
    @(negedge clk);
    drive(OP_DIVU, 32'd1000, 32'd9, 1'b1, "calc_start_first");
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    drive(OP_REMU, 32'd77, 32'd10, 1'b0, "");
    @(negedge clk);
    bus.start_i = 1'b0;
    drain(W + 10);
    repeat (4) @(negedge clk);

    // Back-to-back: second op accepted in the DONE cycle.
    drive(OP_DIV, 32'd300, 32'hFFFF_FFFD, 1'b1, "b2b_first");
    @(negedge clk);
    bus.start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done_o;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL b2b_wait actual=no_done required=done");
    end
    drive(OP_REMU, 32'hDEAD_BEEF, 32'd1000, 1'b1, "b2b_second");
    @(negedge clk);
    bus.start_i = 1'b0;
    drain(W + 10);

    // Flush during DONE: pulse still seen, next request dropped, idle after.
    @(negedge clk);
    drive(OP_DIVU, 32'd8, 32'd0, 1'b1, "done_flush_pulse");
    @(negedge clk);
    drive(OP_DIVU, 32'd40, 32'd6, 1'b0, "");
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    chk("done_flush_busy", 32'(bus.busy_o), 32'd0);
    chk("done_flush_done", 32'(bus.done_o), 32'd0);
    drain(4);

    // Random sweep mixing corner operands.
    for (int n = 0; n < 1500; n++) begin
      run(ops[$urandom_range(0, 3)], pick(), pick(), "rand");
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
